// File: rtl/baseball_pkg.sv
// Shared types and constants for the number-baseball game blocks:
// controller state encoding, winner codes and the default guess geometry.
package baseball_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_P,
    SEND,
    WAIT_RES,
    DONE
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int DIGITS_DEF  = 3;
  localparam int DIGIT_W_DEF = 4;

endpackage

// File: rtl/guess_validator.sv
// Combinational legality check of a guess: every digit must be BCD (0..9)
// and no two digits may be equal. Used by guess_turn_ctrl only when the
// GUESS_CHECK_EN build option is defined.
module guess_validator
  import baseball_pkg::*;
#(
  parameter int DIGITS  = DIGITS_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input  logic [DIGITS*DIGIT_W-1:0] digits_in,
  output logic                      digits_ok
);

  // Clear digits_ok on any out-of-range digit or any repeated digit pair.
  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) digits_ok = 1'b0;
      for (int j = i + 1; j < DIGITS; j++) begin
        if (digits_in[i*DIGIT_W +: DIGIT_W] == digits_in[j*DIGIT_W +: DIGIT_W])
          digits_ok = 1'b0;
      end
    end
  end

endmodule

// File: rtl/guess_turn_ctrl.sv
// Turn controller for the two-player guessing game. Accepts the release
// pulse of the player whose turn it is, latches that player's digits,
// offers the guess to the scorer over valid/ready, waits for the verdict,
// counts attempts and declares winner, draw or game over.
// Build option GUESS_CHECK_EN: reject (turn_err) guesses with non-BCD or
// repeated digits instead of forwarding them.
module guess_turn_ctrl
  import baseball_pkg::*;
#(
  parameter int DIGITS    = DIGITS_DEF,
  parameter int DIGIT_W   = DIGIT_W_DEF,
  parameter int MAX_TRIES = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      guess_mode,
  input  logic                      released_p1,
  input  logic                      released_p2,
  input  logic [DIGITS*DIGIT_W-1:0] digits_in,
  output logic                      guess_valid,
  input  logic                      guess_ready,
  output logic                      guess_player,
  output logic [DIGITS*DIGIT_W-1:0] guess_data,
  input  logic                      result_valid,
  input  logic                      result_win,
  output logic                      turn,
  output logic [3:0]                tries_p1,
  output logic [3:0]                tries_p2,
  output logic                      turn_err,
  output logic [1:0]                winner,
  output logic                      game_over
);

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  state_t     state;
  logic       digits_ok;
  logic       turn_rel;
  logic       other_rel;
  logic [3:0] nxt_p1;
  logic [3:0] nxt_p2;

  // Attempt counters stop at 15 instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

`ifdef GUESS_CHECK_EN
  guess_validator #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W)
  ) u_validator (
    .digits_in (digits_in),
    .digits_ok (digits_ok)
  );
`else
  assign digits_ok = 1'b1;
`endif

  // Sort the release pulses into turn / non-turn player and precompute
  // the attempt counters as they will be after the pending verdict.
  always_comb begin
    turn_rel  = turn ? released_p2 : released_p1;
    other_rel = turn ? released_p1 : released_p2;
    nxt_p1    = (guess_player == 1'b0) ? sat_inc(tries_p1) : tries_p1;
    nxt_p2    = (guess_player == 1'b1) ? sat_inc(tries_p2) : tries_p2;
  end

  // Game FSM with all outputs registered; reset clears everything at once,
  // including a guess that is being offered to the scorer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      guess_valid  <= 1'b0;
      guess_player <= 1'b0;
      guess_data   <= '0;
      turn         <= 1'b0;
      tries_p1     <= 4'd0;
      tries_p2     <= 4'd0;
      turn_err     <= 1'b0;
      winner       <= WIN_NONE;
      game_over    <= 1'b0;
    end else begin
      turn_err <= 1'b0;
      case (state)
        IDLE: begin
          if (guess_mode) state <= WAIT_P;
        end
        WAIT_P: begin
          // Leaving the guessing phase wins over any press in this cycle.
          if (!guess_mode) begin
            state <= IDLE;
          end else begin
            if (other_rel) turn_err <= 1'b1;
            if (turn_rel) begin
              if (digits_ok) begin
                guess_data   <= digits_in;
                guess_player <= turn;
                guess_valid  <= 1'b1;
                state        <= SEND;
              end else begin
                turn_err <= 1'b1;
              end
            end
          end
        end
        SEND: begin
          if (guess_ready) begin
            guess_valid <= 1'b0;
            state       <= WAIT_RES;
          end
        end
        WAIT_RES: begin
          if (result_valid) begin
            tries_p1 <= nxt_p1;
            tries_p2 <= nxt_p2;
            if (result_win) begin
              winner    <= guess_player ? WIN_P2 : WIN_P1;
              game_over <= 1'b1;
              state     <= DONE;
            end else if (nxt_p1 == MAX_T && nxt_p2 == MAX_T) begin
              winner    <= WIN_DRAW;
              game_over <= 1'b1;
              state     <= DONE;
            end else begin
              turn  <= ~turn;
              state <= WAIT_P;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guess_turn_ctrl.sv
// Self-checking bench for guess_turn_ctrl: hand-written sequences for the
// handshake and turn corner cases, a vector table for full games, and a
// scoreboard that checks every guess the scorer accepts.
module tb_guess_turn_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        guess_mode;
  logic        released_p1;
  logic        released_p2;
  logic [11:0] digits_in;
  logic        guess_valid;
  logic        guess_ready;
  logic        guess_player;
  logic [11:0] guess_data;
  logic        result_valid;
  logic        result_win;
  logic        turn;
  logic [3:0]  tries_p1;
  logic [3:0]  tries_p2;
  logic        turn_err;
  logic [1:0]  winner;
  logic        game_over;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        player;
    logic [11:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t sb_e;

  typedef struct {
    logic        start;
    logic        player;
    logic [11:0] digits;
    logic        win;
    logic [3:0]  e_t1;
    logic [3:0]  e_t2;
    logic        e_turn;
    logic [1:0]  e_win;
    logic        e_go;
  } vec_t;
  vec_t vec[20];

  logic [11:0] legal[4];

  guess_turn_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .guess_mode   (guess_mode),
    .released_p1  (released_p1),
    .released_p2  (released_p2),
    .digits_in    (digits_in),
    .guess_valid  (guess_valid),
    .guess_ready  (guess_ready),
    .guess_player (guess_player),
    .guess_data   (guess_data),
    .result_valid (result_valid),
    .result_win   (result_win),
    .turn         (turn),
    .tries_p1     (tries_p1),
    .tries_p2     (tries_p2),
    .turn_err     (turn_err),
    .winner       (winner),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    guess_mode   = 1'b0;
    released_p1  = 1'b0;
    released_p2  = 1'b0;
    digits_in    = 12'h000;
    guess_ready  = 1'b0;
    result_valid = 1'b0;
    result_win   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // One full turn: press, zero-wait acceptance, then the verdict.
  task automatic do_turn(input logic player, input logic [11:0] d, input logic win);
    guess_ready = 1'b1;
    released_p1 = (player == 1'b0);
    released_p2 = (player == 1'b1);
    digits_in   = d;
    sb.push_back('{player: player, data: d});
    step();
    released_p1 = 1'b0;
    released_p2 = 1'b0;
    chk("turn_valid", guess_valid, 1'b1);
    step();
    guess_ready  = 1'b0;
    result_valid = 1'b1;
    result_win   = win;
    step();
    result_valid = 1'b0;
    result_win   = 1'b0;
  endtask

  // Scoreboard: each handshake the scorer will take at the next edge.
  always @(negedge clk) begin
    if (!rst && guess_valid && guess_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got guess %0h, expected none", guess_data);
      end else begin
        sb_e = sb.pop_front();
        chk("sb_player", guess_player, sb_e.player);
        chk("sb_data", guess_data, sb_e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    legal[0] = 12'h123;
    legal[1] = 12'h456;
    legal[2] = 12'h789;
    legal[3] = 12'h902;
    // Entries 0..13: alternating non-win turns ending in a draw.
    for (int i = 0; i < 14; i++) begin
      vec[i].start  = (i == 0);
      vec[i].player = i[0];
      vec[i].digits = legal[i % 4];
      vec[i].win    = 1'b0;
      vec[i].e_t1   = 4'((i + 2) / 2);
      vec[i].e_t2   = 4'((i + 1) / 2);
      vec[i].e_turn = (i == 13) ? 1'b1 : ~i[0];
      vec[i].e_win  = (i == 13) ? 2'b11 : 2'b00;
      vec[i].e_go   = (i == 13);
    end
    // Entries 14..19: new game, P2 wins on its third try.
    vec[14] = '{1'b1, 1'b0, 12'h123, 1'b0, 4'd1, 4'd0, 1'b1, 2'b00, 1'b0};
    vec[15] = '{1'b0, 1'b1, 12'h456, 1'b0, 4'd1, 4'd1, 1'b0, 2'b00, 1'b0};
    vec[16] = '{1'b0, 1'b0, 12'h789, 1'b0, 4'd2, 4'd1, 1'b1, 2'b00, 1'b0};
    vec[17] = '{1'b0, 1'b1, 12'h902, 1'b0, 4'd2, 4'd2, 1'b0, 2'b00, 1'b0};
    vec[18] = '{1'b0, 1'b0, 12'h135, 1'b0, 4'd3, 4'd2, 1'b1, 2'b00, 1'b0};
    vec[19] = '{1'b0, 1'b1, 12'h246, 1'b1, 4'd3, 4'd3, 1'b1, 2'b10, 1'b1};

    // Reset state.
    rst = 1'b1;
    clear_inputs();
    step();
    chk("rst_valid", guess_valid, 1'b0);
    chk("rst_data", guess_data, 12'h000);
    chk("rst_turn", turn, 1'b0);
    chk("rst_tries", {tries_p1, tries_p2}, 8'h00);
    chk("rst_winner", winner, 2'b00);
    chk("rst_game_over", game_over, 1'b0);
    rst = 1'b0;
    step();

    // First guess from P1 with ready held high.
    guess_mode = 1'b1;
    step();
    guess_ready = 1'b1;
    released_p1 = 1'b1;
    digits_in   = 12'h123;
    sb.push_back('{player: 1'b0, data: 12'h123});
    step();
    released_p1 = 1'b0;
    chk("t1_valid", guess_valid, 1'b1);
    chk("t1_data", guess_data, 12'h123);
    chk("t1_player", guess_player, 1'b0);
    step();
    chk("t1_valid_drop", guess_valid, 1'b0);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    chk("t1_tries_p1", tries_p1, 4'd1);
    chk("t1_turn", turn, 1'b1);

    // P2 turn to bring the turn back to P1.
    released_p2 = 1'b1;
    digits_in   = 12'h345;
    sb.push_back('{player: 1'b1, data: 12'h345});
    step();
    released_p2 = 1'b0;
    step();
    guess_ready  = 1'b0;
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    chk("t2_tries_p2", tries_p2, 4'd1);
    chk("t2_turn", turn, 1'b0);

    // Out-of-turn press, then simultaneous presses.
    released_p2 = 1'b1;
    step();
    released_p2 = 1'b0;
    chk("oot_err", turn_err, 1'b1);
    chk("oot_valid", guess_valid, 1'b0);
    step();
    chk("oot_err_pulse", turn_err, 1'b0);
    released_p1 = 1'b1;
    released_p2 = 1'b1;
    digits_in   = 12'h456;
    sb.push_back('{player: 1'b0, data: 12'h456});
    step();
    released_p1 = 1'b0;
    released_p2 = 1'b0;
    chk("both_err", turn_err, 1'b1);
    chk("both_valid", guess_valid, 1'b1);
    chk("both_player", guess_player, 1'b0);

    // Backpressure: ready low for 5 cycles while digits_in moves; presses
    // and stray verdicts meanwhile must be ignored.
    for (int i = 0; i < 5; i++) begin
      digits_in    = 12'($urandom_range(0, 4095));
      released_p2  = (i == 2);
      result_valid = (i == 2);
      step();
      released_p2  = 1'b0;
      result_valid = 1'b0;
      chk("bp_valid", guess_valid, 1'b1);
      chk("bp_data", guess_data, 12'h456);
      chk("bp_err", turn_err, 1'b0);
      chk("bp_tries", tries_p1, 4'd1);
    end
    guess_ready = 1'b1;
    step();
    guess_ready = 1'b0;
    chk("bp_valid_drop", guess_valid, 1'b0);
    result_valid = 1'b1;
    step();
    result_valid = 1'b0;
    chk("bp_tries_p1", tries_p1, 4'd2);
    chk("bp_turn", turn, 1'b1);

    // guess_mode low takes priority over a same-cycle press; IDLE ignores presses.
    guess_mode  = 1'b0;
    released_p2 = 1'b1;
    step();
    chk("mode_valid", guess_valid, 1'b0);
    chk("mode_err", turn_err, 1'b0);
    step();
    released_p2 = 1'b0;
    chk("idle_valid", guess_valid, 1'b0);
    chk("idle_keep", {3'b000, turn, tries_p1, tries_p2}, {3'b000, 1'b1, 4'd2, 4'd1});

`ifdef GUESS_CHECK_EN
    // Illegal guesses are refused without consuming an attempt.
    do_reset();
    guess_mode  = 1'b1;
    step();
    guess_ready = 1'b1;
    released_p1 = 1'b1;
    digits_in   = 12'h113;
    step();
    chk("chk_dup_err", turn_err, 1'b1);
    chk("chk_dup_valid", guess_valid, 1'b0);
    digits_in   = 12'h1A2;
    step();
    released_p1 = 1'b0;
    guess_ready = 1'b0;
    chk("chk_bcd_err", turn_err, 1'b1);
    chk("chk_bcd_valid", guess_valid, 1'b0);
    chk("chk_tries", {tries_p1, tries_p2}, 8'h00);
`endif

    // Table-driven full games.
    for (int i = 0; i < 20; i++) begin
      if (vec[i].start) begin
        do_reset();
        guess_mode = 1'b1;
        step();
      end
      do_turn(vec[i].player, vec[i].digits, vec[i].win);
      chk($sformatf("vec%0d_t1", i), tries_p1, vec[i].e_t1);
      chk($sformatf("vec%0d_t2", i), tries_p2, vec[i].e_t2);
      chk($sformatf("vec%0d_turn", i), turn, vec[i].e_turn);
      chk($sformatf("vec%0d_winner", i), winner, vec[i].e_win);
      chk($sformatf("vec%0d_go", i), game_over, vec[i].e_go);
      if (i == 13) begin
        // DONE ignores everything.
        guess_ready  = 1'b1;
        released_p1  = 1'b1;
        released_p2  = 1'b1;
        result_valid = 1'b1;
        result_win   = 1'b1;
        step();
        step();
        clear_inputs();
        guess_mode = 1'b1;
        chk("done_valid", guess_valid, 1'b0);
        chk("done_err", turn_err, 1'b0);
        chk("done_state", {2'b00, game_over, winner, tries_p1, tries_p2},
            {2'b00, 1'b1, 2'b11, 4'd7, 4'd7});
      end
    end

    // Asynchronous reset while a guess is being offered.
    do_reset();
    guess_mode  = 1'b1;
    step();
    released_p1 = 1'b1;
    digits_in   = 12'h987;
    step();
    released_p1 = 1'b0;
    chk("ar_valid_before", guess_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", guess_valid, 1'b0);
    chk("ar_outputs", {guess_player, guess_data, turn, tries_p1, tries_p2, turn_err, winner, game_over},
        32'h0);
    step();
    rst = 1'b0;
    clear_inputs();
    step();

    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/guess_turn_ctrl.md
Name: guess_turn_ctrl

Overview:
- Consumer of the per-player guess-button edge pulses.
- Enforces alternating turns (P1 first) and latches the active player's digit switches on a valid release.
- Hands the latched guess to the scoring block over a valid/ready handshake, waits for its verdict, and counts attempts per player.
- Declares winner, draw or game over.

Parameters:
- DIGITS, 3: digits per guess.
- DIGIT_W, 4: bits per digit (BCD).
- MAX_TRIES, 7: attempts allowed per player; must be at most 15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- guess_mode  in  1  guessing phase enable
- released_p1  in  1  one-cycle P1 button-release pulse
- released_p2  in  1  one-cycle P2 button-release pulse
- digits_in  in  DIGITS*DIGIT_W  switch value of the current guess
- guess_valid  out  1  guess offered to scorer
- guess_ready  in  1  scorer accepts the guess
- guess_player  out  1  0=P1, 1=P2; valid with guess_valid
- guess_data  out  DIGITS*DIGIT_W  latched guess
- result_valid  in  1  one-cycle scorer verdict strobe
- result_win  in  1  guess hit all strikes; qualified by result_valid
- turn  out  1  player whose turn it is
- tries_p1  out  4  completed attempts, P1
- tries_p2  out  4  completed attempts, P2
- turn_err  out  1  one-cycle pulse: rejected press
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw
- game_over  out  1  high in DONE

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock.
  - All outputs are 0 during reset, and the state is IDLE.
  - Reset mid-operation aborts any handshake immediately; guess_valid drops asynchronously.
- States: IDLE, WAIT_P, SEND, WAIT_RES, DONE.
- IDLE:
  - Go to WAIT_P when guess_mode=1.
  - turn, tries and winner keep their values.
- WAIT_P:
  - If guess_mode=0, go to IDLE. This check has priority over any pulse in the same cycle.
  - If the released pulse of the current turn arrives in cycle n, latch digits_in as sampled in cycle n into guess_data and guess_player=turn. guess_valid=1 from cycle n+1, state SEND.
  - A release from the non-turn player pulses turn_err in cycle n+1 and is otherwise ignored.
  - If both pulses arrive in the same cycle, the turn player's pulse is accepted and turn_err pulses for the other.
- SEND:
  - guess_valid, guess_data and guess_player stay stable until guess_valid&&guess_ready is seen at a clock edge. After that edge guess_valid=0 and the state is WAIT_RES.
  - Zero-wait acceptance is allowed: valid at n+1 with ready at n+1 gives WAIT_RES at n+2.
- WAIT_RES:
  - On result_valid, increment tries of guess_player; the counter saturates at 15.
  - result_win=1: winner = guess_player+1, state DONE.
  - Otherwise, if tries_p1==MAX_TRIES and tries_p2==MAX_TRIES after the increment: winner=11, state DONE.
  - Otherwise toggle turn and return to WAIT_P.
  - Any result_valid outside WAIT_RES is ignored.
- guess_mode=0 during SEND or WAIT_RES is ignored; the exchange completes first, then the WAIT_P rule applies.
- Release pulses outside WAIT_P are ignored and do not raise turn_err.
- DONE: game_over=1. Stay until rst; every input is ignored.
- Output timing: all outputs are registered. Counter and turn updates are visible the cycle after result_valid.

Optional Feature:
- Macro: GUESS_CHECK_EN.
- When defined:
  - An accepted-turn release whose digits_in holds any digit >9, or any two equal digits, is rejected with a turn_err pulse at n+1.
  - The state stays WAIT_P and no attempt is consumed.
- When undefined: any digits_in value is forwarded unchecked.

Decomposition:
- Shared package baseball_pkg holds:
  - the state enum;
  - the winner codes WIN_NONE/WIN_P1/WIN_P2/WIN_DRAW;
  - the default DIGITS/DIGIT_W constants.
- One sub-module, guess_validator: combinational range and duplicate check over digits_in. It is instantiated only under GUESS_CHECK_EN.

Test Plan:
- Reset, guess_mode=1, released_p1 with digits_in=0x123, guess_ready held 1 -> guess_valid for exactly 1 cycle at n+1, guess_data=0x123, guess_player=0, then WAIT_RES.
- In WAIT_P with turn=0, released_p2 -> turn_err pulse, no guess_valid. Same-cycle released_p1+released_p2 -> guess accepted for P1 and turn_err=1.
- guess_ready held 0 for 5 cycles while digits_in changes -> guess_valid and guess_data stay stable. Ready on cycle 6 -> valid drops next cycle.
- Seven non-win results each for P1 and P2, alternating -> tries_p1=tries_p2=7, winner=11, game_over=1. Further pulses are ignored.
- P2 result_win on its 3rd try -> winner=10, game_over=1, tries_p2=3, tries_p1=3.
- With GUESS_CHECK_EN: digits_in=0x113 or 0x1A2 -> turn_err, no guess_valid, tries unchanged. Assert rst during SEND -> all outputs 0 immediately.
